// File: rtl/proc_trace_pkg.sv
// Shared types for the processor trace receiver: FSM states, the buffered trace record
// and the drop-counter ceiling.
package proc_trace_pkg;

    localparam int unsigned TRACE_SEQ_W = 4;
    localparam logic [7:0]  DROP_MAX    = 8'd255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HALTED  = 2'd2
    } trace_state_t;

    typedef struct packed {
        logic [3:0]             pc;
        logic [3:0]             result;
        logic [TRACE_SEQ_W-1:0] seq;
    } trace_rec_t;

endpackage

// File: rtl/proc_trace_fifo.sv
// Synchronous FIFO of trace records; pointers carry an extra wrap bit so full and empty
// can be told apart, and a push is accepted alongside a pop when full.
module proc_trace_fifo
    import proc_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  trace_rec_t push_rec,
    input  logic       pop,
    output trace_rec_t head,
    output logic       empty,
    output logic       full
);

    localparam int unsigned AW = $clog2(DEPTH);

    trace_rec_t      mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Storage is not reset, so the head reads as zero whenever nothing is queued.
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_rec;
    end

endmodule

// File: rtl/proc_trace_rx.sv
// Trace receiver: samples pc/result while enabled, keeps only samples where pc moved,
// tags them with a sequence number and queues them for a valid/ready consumer.
module proc_trace_rx
    import proc_trace_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SEQ_W       = TRACE_SEQ_W,
    parameter int unsigned HALT_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       pc,
    input  logic [3:0]       result,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [3:0]       out_pc,
    output logic [3:0]       out_result,
    output logic [SEQ_W-1:0] out_seq,
    output logic             halted,
    output logic             overflow,
    output logic [7:0]       drop_count
);

    localparam int unsigned RCW = $clog2(HALT_CYCLES + 1);

    trace_state_t     state, state_d;
    logic [3:0]       last_pc, last_pc_d;
    logic             have_last, have_last_d;
    logic [RCW-1:0]   rep_cnt, rep_cnt_d;
    logic [SEQ_W-1:0] seq;
    logic             attempt, push, pop, drop;
    logic             empty, full;
    trace_rec_t       head, push_rec;

    always_comb begin
        state_d     = state;
        last_pc_d   = last_pc;
        have_last_d = have_last;
        rep_cnt_d   = rep_cnt;
        attempt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_d     = CAPTURE;
                    rep_cnt_d   = '0;
                    have_last_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (!have_last || pc != last_pc) begin
                    attempt     = 1'b1;
                    rep_cnt_d   = '0;
                    have_last_d = 1'b1;
                    last_pc_d   = pc;
                end else begin
                    rep_cnt_d = rep_cnt + RCW'(1);
                    if (rep_cnt_d == RCW'(HALT_CYCLES)) state_d = HALTED;
                end
            end
            HALTED: begin
                if (!en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still takes the push when the head leaves on the same edge.
    assign pop      = out_val && out_rdy;
    assign push     = attempt && (!full || pop);
    assign drop     = attempt && full && !pop;
    assign push_rec = '{pc: pc, result: result, seq: seq};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_pc    <= '0;
            have_last  <= 1'b0;
            rep_cnt    <= '0;
            seq        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state     <= state_d;
            last_pc   <= last_pc_d;
            have_last <= have_last_d;
            rep_cnt   <= rep_cnt_d;
            if (attempt) seq <= seq + SEQ_W'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != DROP_MAX) drop_count <= drop_count + 8'd1;
            end
        end
    end

    proc_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_rec (push_rec),
        .pop      (pop),
        .head     (head),
        .empty    (empty),
        .full     (full)
    );

    assign out_val    = !empty;
    assign out_pc     = head.pc;
    assign out_result = head.result;
    assign out_seq    = head.seq;
    assign halted     = (state == HALTED);

endmodule

// File: tb/tb_proc_trace_rx.sv
// Bench for proc_trace_rx: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_proc_trace_rx;

    localparam int DEPTH = 4;
    localparam int SEQ_W = 4;
    localparam int HALT  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [3:0] pc = '0;
    logic [3:0] result = '0;
    logic       out_rdy = 1'b0;
    logic       out_val;
    logic [3:0] out_pc;
    logic [3:0] out_result;
    logic [SEQ_W-1:0] out_seq;
    logic       halted;
    logic       overflow;
    logic [7:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    proc_trace_rx #(
        .DEPTH       (DEPTH),
        .SEQ_W       (SEQ_W),
        .HALT_CYCLES (HALT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .pc         (pc),
        .result     (result),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_pc     (out_pc),
        .out_result (out_result),
        .out_seq    (out_seq),
        .halted     (halted),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = waiting for enable, 1 = capturing, 2 = halted.
    int          m_mode = 0;
    bit          m_have = 0;
    int          m_last = 0;
    int          m_rep = 0;
    int          m_seq = 0;
    int          m_drops = 0;
    bit          m_ovf = 0;
    logic [11:0] mq[$];
    logic [11:0] dut_log[$];

    task automatic model_reset();
        m_mode = 0; m_have = 0; m_last = 0; m_rep = 0;
        m_seq = 0; m_drops = 0; m_ovf = 0;
        mq.delete();
    endtask

    task automatic model_step();
        bit keep = 0;
        bit leave = (mq.size() != 0) && out_rdy;
        if (m_mode == 0) begin
            if (en) begin m_mode = 1; m_have = 0; m_rep = 0; end
        end else if (m_mode == 1) begin
            if (!en) m_mode = 0;
            else if (!m_have || int'(pc) != m_last) begin
                keep = 1; m_have = 1; m_last = int'(pc); m_rep = 0;
            end else begin
                m_rep++;
                if (m_rep == HALT) m_mode = 2;
            end
        end else if (!en) begin
            m_mode = 0;
        end
        if (leave) void'(mq.pop_front());
        if (keep) begin
            if (mq.size() < DEPTH) mq.push_back({pc, result, 4'(m_seq)});
            else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
            m_seq = (m_seq + 1) % (1 << SEQ_W);
        end
    endtask

    always @(posedge clk) if (reset) model_step();

    always @(negedge clk) begin
        check("out_val", out_val, mq.size() != 0);
        if (mq.size() != 0) begin
            check("out_pc", out_pc, mq[0][11:8]);
            check("out_result", out_result, mq[0][7:4]);
            check("out_seq", out_seq, mq[0][3:0]);
            if (out_val && out_rdy) dut_log.push_back({out_pc, out_result, out_seq});
        end
        check("halted", halted, m_mode == 2);
        check("overflow", overflow, m_ovf);
        check("drop_count", drop_count, m_drops);
    end

    task automatic step(input logic e, input logic [3:0] p, input logic [3:0] r,
                        input logic rdy);
        en = e; pc = p; result = r; out_rdy = rdy;
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; asserts reset between edges and releases it later.
    task automatic async_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_out_val", out_val, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_count", drop_count, 0);
        en = 0; out_rdy = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    int cnt;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_out_val", out_val, 0);
        check("init_out_pc", out_pc, 0);
        check("init_out_seq", out_seq, 0);
        check("init_halted", halted, 0);
        check("init_drop_count", drop_count, 0);
        reset = 1'b1;

        // Stepping pc with a ready consumer: one record per sample, visible right after it.
        dut_log.delete();
        step(1, 0, 5, 1);
        check("t1_enter_out_val", out_val, 0);
        step(1, 0, 5, 1);
        check("t1_first_val", out_val, 1);
        check("t1_first_seq", out_seq, 0);
        check("t1_first_result", out_result, 5);
        step(1, 1, 6, 1);
        step(1, 2, 7, 1);
        step(1, 3, 8, 1);
        step(1, 3, 8, 1);
        check("t1_log_size", dut_log.size(), 4);
        for (int i = 0; i < 4 && i < dut_log.size(); i++) begin
            check("t1_log_pc", dut_log[i][11:8], i);
            check("t1_log_result", dut_log[i][7:4], 5 + i);
            check("t1_log_seq", dut_log[i][3:0], i);
        end
        check("t1_overflow", overflow, 0);

        // Held pc leads to a halt; dropping enable leaves it.
        dut_log.delete();
        step(1, 5, 1, 1);
        step(1, 6, 2, 1);
        step(1, 6, 2, 1);
        step(1, 6, 2, 1);
        check("t2_not_yet_halted", halted, 0);
        step(1, 6, 2, 1);
        check("t2_halted", halted, 1);
        step(0, 6, 2, 1);
        check("t2_halt_cleared", halted, 0);
        cnt = 0;
        foreach (dut_log[i]) if (dut_log[i][11:8] == 4'd6) cnt++;
        check("t2_pc6_records", cnt, 1);

        // Stalled consumer: 6 attempts, 4 kept, 2 dropped, sequence keeps counting.
        async_reset();
        dut_log.delete();
        step(1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) step(1, 4'(i), 4'(i), 0);
        check("t3_overflow", overflow, 1);
        check("t3_drop_count", drop_count, 2);
        repeat (5) step(0, 0, 0, 1);
        check("t3_log_size", dut_log.size(), 4);
        for (int i = 0; i < 4 && i < dut_log.size(); i++)
            check("t3_log_seq", dut_log[i][3:0], i);
        step(1, 9, 9, 1);
        step(1, 9, 9, 1);
        check("t3_next_seq", out_seq, 6);

        // Full FIFO with a simultaneous pop and push: nothing is dropped.
        async_reset();
        dut_log.delete();
        step(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(1, 4'(i), 4'(i), 0);
        check("t4_full_val", out_val, 1);
        step(1, 5, 5, 1);
        check("t4_drop_count", drop_count, 0);
        check("t4_head_seq", out_seq, 1);
        repeat (6) step(0, 0, 0, 1);
        check("t4_log_size", dut_log.size(), 5);
        for (int i = 0; i < 5 && i < dut_log.size(); i++)
            check("t4_log_seq", dut_log[i][3:0], i);

        // Twenty distinct samples: the sequence number wraps 15 -> 0.
        async_reset();
        dut_log.delete();
        step(1, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(1, 4'(i), 4'(i + 3), 1);
        repeat (2) step(0, 0, 0, 1);
        check("t5_drop_count", drop_count, 0);
        check("t5_log_size", dut_log.size(), 20);
        if (dut_log.size() >= 17) begin
            check("t5_seq15", dut_log[15][3:0], 15);
            check("t5_seq_wrap", dut_log[16][3:0], 0);
        end

        // Reset mid-stream with entries queued.
        async_reset();
        step(1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) step(1, 4'(i), 0, 0);
        check("t6_queued_val", out_val, 1);
        async_reset();
        step(1, 7, 0, 1);
        check("t6_idle_after_reset", out_val, 0);
        step(1, 7, 0, 1);
        check("t6_seq_restart", out_seq, 0);

        // Randomized traffic; the negedge compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] npc;
            if ($urandom_range(0, 399) == 0) async_reset();
            npc = ($urandom_range(0, 1) == 0) ? pc : 4'($urandom_range(0, 15));
            step($urandom_range(0, 15) != 0, npc, 4'($urandom), $urandom_range(0, 9) < 6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/proc_trace_rx.md
# proc_trace_rx

Trace receiver at the consuming end of the processor's `pc`/`result` outputs. It samples the pair every cycle while enabled and suppresses samples where `pc` has not changed. Each kept sample is tagged with a sequence number and buffered in a small FIFO, then handed to a downstream checker or host over a valid/ready interface. It also flags a halted program when `pc` holds still, and records overflow when the FIFO cannot accept a sample.

## Interface
- `DEPTH`, 4: FIFO entries; a power of two, at least 2.
- `SEQ_W`, 4: sequence-number width.
- `HALT_CYCLES`, 3: number of consecutive repeated-`pc` samples that declares a halt; at least 1.
- `clk`  in  1  the only clock.
- `reset`  in  1  asynchronous, active-low reset: 0 resets the block.
- `en`  in  1  capture enable.
- `pc`  in  4  processor program counter.
- `result`  in  4  processor result.
- `out_val`  out  1  the FIFO head is valid.
- `out_rdy`  in  1  the consumer accepts the head.
- `out_pc`  out  4  `pc` of the head record.
- `out_result`  out  4  `result` of the head record.
- `out_seq`  out  SEQ_W  sequence number of the head record.
- `halted`  out  1  a halt has been detected.
- `overflow`  out  1  sticky: at least one sample was dropped.
- `drop_count`  out  8  number of dropped samples, saturating at 255.

## Operation
- States:
  - IDLE: reset state; nothing is sampled.
  - CAPTURE: samples `pc`/`result` every cycle.
  - HALTED: capture stops; `halted`=1.
- Transitions:
  - IDLE→CAPTURE when `en`=1.
  - CAPTURE→IDLE when `en`=0.
  - CAPTURE→HALTED when the repeat counter reaches `HALT_CYCLES`.
  - HALTED→IDLE when `en`=0.
- CAPTURE, per cycle:
  - The first sample after entering CAPTURE is always a "new" sample.
  - A sample is "new" when `pc` differs from the last sampled `pc`.
  - A new sample resets the repeat counter to 0 and makes a push attempt of {pc, result, seq}.
  - A repeated `pc` makes no push attempt and increments the repeat counter.
- Sequence numbers:
  - `seq` increments on every push attempt, whether the push is accepted or dropped, so gaps in `out_seq` reveal drops.
  - `seq` wraps modulo 2^SEQ_W.
- Full FIFO:
  - A push attempt is dropped when the FIFO is full and `out_rdy`=0.
  - A drop sets `overflow` and increments `drop_count`, which saturates.
  - When the FIFO is full and `out_rdy`=1 with `out_val`=1 in the same cycle, the pop and the push both happen; the push is not dropped.
- Draining continues in every state, IDLE and HALTED included.
- `overflow` and `drop_count` clear only on reset.
- IDLE→CAPTURE keeps `seq` and the FIFO contents, and clears the repeat counter and the last-`pc` history.

## Timing
- Reset values:
  - state is IDLE;
  - `out_val`=0 and the FIFO is empty;
  - `out_pc`, `out_result` and `out_seq` are 0;
  - `halted`=0, `overflow`=0, `drop_count`=0;
  - `seq`=0 and the repeat counter is 0.
- Reset is asynchronous: asserting it mid-operation immediately empties the FIFO and forces IDLE. Data in flight is lost.
- Latency: a sample taken at edge k into an empty FIFO gives `out_val`=1 with that record after edge k.
- The head updates on the edge on which `out_val` and `out_rdy` are both 1.
- The head data is held stable while `out_val`=1 and `out_rdy`=0.
- `halted` rises on the edge of the sample that brings the repeat count to `HALT_CYCLES`. It falls on the edge on which `en`=0 is sampled in HALTED.
- Throughput is one push and one pop per cycle.

## Structure
- Package `proc_trace_pkg`:
  - state enum `trace_state_t` {IDLE, CAPTURE, HALTED};
  - `trace_rec_t` struct {pc[3:0], result[3:0], seq}, parameterised by `SEQ_W` through a package-level localparam default;
  - the `DROP_MAX` (255) constant.
- Sub-module `proc_trace_fifo`:
  - a generic synchronous FIFO of `trace_rec_t`, `DEPTH` entries;
  - pointers are one bit wider than the address for the full/empty test;
  - simultaneous push and pop is legal when full.
- The top level holds the FSM, the last-`pc` register, the repeat counter, `seq`, and the overflow logic.

## Test plan
- Reset, then `en`=1 with `pc` stepping 0,1,2,3 and `result`=5,6,7,8, `out_rdy`=1 → records (0,5,0), (1,6,1), (2,7,2), (3,8,3), each appearing one cycle after its sample; `overflow`=0.
- `pc` held at 6 after 5 → one record for `pc`=6; `halted`=1 after 3 repeat samples; `en`=0 → IDLE and `halted`=0.
- `out_rdy`=0 with 6 distinct `pc` values and `DEPTH`=4 → FIFO holds seq 0..3; `overflow`=1, `drop_count`=2; later drain gives seq 0,1,2,3; the next capture gets seq 6.
- FIFO full, and in the same cycle `out_rdy`=1 with a new `pc` → pop and push both occur; `drop_count` is unchanged.
- 20 distinct samples with `out_rdy`=1 → `out_seq` wraps 15→0; no drops.
- Drive `reset`=0 mid-stream with 3 entries queued → `out_val`=0 immediately; after release, state IDLE and `seq` restarts at 0.
